ceespu_pipe_ctrl: RTL
=====================

CEESPU_PIPE_CTRL -- requirements
Module: ceespu_pipe_ctrl

Interface
REQ-001 SHALL have port I_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port I_rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port I_dec_valid, input, 1 bit: the decode stage holds a real instruction.
REQ-004 SHALL have ports I_dec_selA and I_dec_selB, inputs, 5 bits each: decode source register indices.
REQ-005 SHALL have ports I_dec_useA and I_dec_useB, inputs, 1 bit each: the matching source is actually read.
REQ-006 SHALL have ports I_ex_selD (5 bits), I_ex_we (1 bit) and I_ex_load (1 bit), inputs: execute-stage destination, write enable, and "instruction is a load".
REQ-007 SHALL have ports I_wb_selD (5 bits) and I_wb_we (1 bit), inputs: registered execute outputs (writeback stage).
REQ-008 SHALL have port I_busy, input, 1 bit: the multicycle ALU in execute is not ready.
REQ-009 SHALL have port I_branch, input, 1 bit: execute resolved a taken branch.
REQ-010 SHALL have port O_stall, output, 1 bit: hold the PC and the fetch/decode registers.
REQ-011 SHALL have port O_bubble, output, 1 bit: load a NOP into execute (we=0, branch=0).
REQ-012 SHALL have port O_flush, output, 1 bit: kill the fetch and decode contents.
REQ-013 SHALL have ports O_fwdA and O_fwdB, outputs, 2 bits each: operand source, 0 = regfile, 1 = execute ALU result, 2 = writeback data, 3 = reserved.
REQ-014 SHALL have port O_stall_cnt, output, 16 bits: saturating count of stall cycles.

Function
REQ-015 SHALL implement FSM states RUN, MC_WAIT and FLUSH.
REQ-016 A hazard on register 0 SHALL never be detected, because r0 is constant zero.
REQ-017 In RUN with I_busy=1: O_stall=1, O_bubble=0, the FSM SHALL go to MC_WAIT, and I_branch SHALL be ignored.
REQ-018 In MC_WAIT: O_stall=1 while I_busy=1; on I_busy=0 the FSM SHALL return to RUN, and I_branch SHALL be evaluated that same cycle.
REQ-019 In RUN with I_branch=1 and I_busy=0: O_flush=1 and O_bubble=1 combinationally, and the FSM SHALL go to FLUSH.
REQ-020 In FLUSH: O_flush=1 and O_bubble=1 for exactly one cycle, then the FSM SHALL go to RUN; hazard stalls SHALL be suppressed in FLUSH.
REQ-021 A load-use hazard exists when I_dec_valid, I_ex_we and I_ex_load are set and a used source equals I_ex_selD (nonzero).
REQ-022 A load-use hazard SHALL cause O_stall=1 and O_bubble=1 for exactly one cycle.
REQ-023 Forward priority SHALL be execute over writeback; when both stages match the same source, O_fwd SHALL be 1.
REQ-024 O_fwdA and O_fwdB SHALL be 0 whenever the matching useX=0.
REQ-025 Event priority SHALL be: reset > I_busy > I_branch > data hazard.
REQ-026 O_stall_cnt SHALL increment on each cycle with O_stall=1 and saturate at 16'hFFFF; it SHALL not wrap.

Reset
REQ-027 While I_rst=0 at a clock edge: state SHALL become RUN and O_stall_cnt SHALL become 0.
REQ-028 During reset: O_flush=1, O_bubble=1, O_stall=0, O_fwdA=0 and O_fwdB=0.
REQ-029 Reset asserted during MC_WAIT or FLUSH SHALL abort that state; the first cycle after release SHALL be RUN with no pending flush.

Configuration
REQ-030 Macro CEESPU_FORWARDING_EN defined: forwarding SHALL follow REQ-023 and REQ-024, and only load-use hazards SHALL stall.
REQ-031 Macro CEESPU_FORWARDING_EN undefined: O_fwdA and O_fwdB SHALL be tied to 0.
REQ-032 Macro CEESPU_FORWARDING_EN undefined: any used-source match against an execute or writeback destination SHALL give O_stall=1 and O_bubble=1 until no match remains (up to 2 cycles).

Structure
REQ-033 Package ceespu_pkg SHALL hold the FSM state encoding and the forward-select constants (FWD_RF=0, FWD_EX=1, FWD_WB=2).
REQ-034 Source/destination comparison SHALL be a combinational sub-module ceespu_hazard_detect, instantiated once.

Verification
REQ-035 The bench SHALL cover: I_busy high 5 cycles -> O_stall high 5 cycles, O_stall_cnt +5, state returns to RUN.
REQ-036 The bench SHALL cover: I_branch pulse in RUN -> O_flush high 2 cycles (the branch cycle plus FLUSH), then 0.
REQ-037 The bench SHALL cover: ex load to r3, decode uses r3 as A -> 1-cycle stall+bubble, then O_fwdA=2.
REQ-038 The bench SHALL cover: ex ALU writes r5, wb writes r5, decode B=r5 -> O_fwdB=1, no stall; same case with r0 -> O_fwdB=0.
REQ-039 The bench SHALL cover: I_busy and I_branch high together -> no flush until busy drops, flush that cycle.
REQ-040 The bench SHALL cover: I_rst=0 mid-FLUSH -> O_stall_cnt=0; after release O_flush=0 with state RUN.

Source files
------------

// File: rtl/ceespu_pkg.sv
// Shared types and constants for the CEESPU pipeline controller.
// Holds the control FSM encoding and the operand forward-select codes.
package ceespu_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MC_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_EX = 2'd1;
   localparam logic [1:0] FWD_WB = 2'd2;

   // The execute stage holds the younger result, so it wins over writeback.
   function automatic logic [1:0] fwd_select(input logic ex_hit, input logic wb_hit);
      if (ex_hit)
         return FWD_EX;
      else if (wb_hit)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/ceespu_hazard_detect.sv
// Combinational source/destination comparator for the CEESPU pipeline.
// Reports per-source matches against execute and writeback, plus load-use.
module ceespu_hazard_detect
   import ceespu_pkg::*;
(
   input  logic       dec_valid,
   input  logic [4:0] dec_sel_a,
   input  logic [4:0] dec_sel_b,
   input  logic       dec_use_a,
   input  logic       dec_use_b,
   input  logic [4:0] ex_sel_d,
   input  logic       ex_we,
   input  logic       ex_load,
   input  logic [4:0] wb_sel_d,
   input  logic       wb_we,
   output logic       ex_hit_a,
   output logic       ex_hit_b,
   output logic       wb_hit_a,
   output logic       wb_hit_b,
   output logic       load_use
);

   logic use_a;
   logic use_b;

   // r0 is hardwired to zero, so it can never carry a dependency.
   assign use_a = dec_valid && dec_use_a && (dec_sel_a != 5'd0);
   assign use_b = dec_valid && dec_use_b && (dec_sel_b != 5'd0);

   assign ex_hit_a = use_a && ex_we && (dec_sel_a == ex_sel_d);
   assign ex_hit_b = use_b && ex_we && (dec_sel_b == ex_sel_d);
   assign wb_hit_a = use_a && wb_we && (dec_sel_a == wb_sel_d);
   assign wb_hit_b = use_b && wb_we && (dec_sel_b == wb_sel_d);

   assign load_use = ex_load && (ex_hit_a || ex_hit_b);

endmodule

// File: rtl/ceespu_pipe_ctrl.sv
// CEESPU pipeline control: stall, bubble, flush, operand forwarding, stall counter.
// Define CEESPU_FORWARDING_EN to enable forwarding; otherwise every RAW hazard stalls.
module ceespu_pipe_ctrl
   import ceespu_pkg::*;
(
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_dec_valid,
   input  logic [4:0]  I_dec_selA,
   input  logic [4:0]  I_dec_selB,
   input  logic        I_dec_useA,
   input  logic        I_dec_useB,
   input  logic [4:0]  I_ex_selD,
   input  logic        I_ex_we,
   input  logic        I_ex_load,
   input  logic [4:0]  I_wb_selD,
   input  logic        I_wb_we,
   input  logic        I_busy,
   input  logic        I_branch,
   output logic        O_stall,
   output logic        O_bubble,
   output logic        O_flush,
   output logic [1:0]  O_fwdA,
   output logic [1:0]  O_fwdB,
   output logic [15:0] O_stall_cnt
);

   state_t state;
   state_t next_state;

   logic ex_hit_a;
   logic ex_hit_b;
   logic wb_hit_a;
   logic wb_hit_b;
   logic load_use;
   logic data_hazard;

   ceespu_hazard_detect u_hazard (
      .dec_valid (I_dec_valid),
      .dec_sel_a (I_dec_selA),
      .dec_sel_b (I_dec_selB),
      .dec_use_a (I_dec_useA),
      .dec_use_b (I_dec_useB),
      .ex_sel_d  (I_ex_selD),
      .ex_we     (I_ex_we),
      .ex_load   (I_ex_load),
      .wb_sel_d  (I_wb_selD),
      .wb_we     (I_wb_we),
      .ex_hit_a  (ex_hit_a),
      .ex_hit_b  (ex_hit_b),
      .wb_hit_a  (wb_hit_a),
      .wb_hit_b  (wb_hit_b),
      .load_use  (load_use)
   );

`ifdef CEESPU_FORWARDING_EN
   assign data_hazard = load_use;
`else
   assign data_hazard = ex_hit_a || ex_hit_b || wb_hit_a || wb_hit_b;
`endif

   always_ff @(posedge I_clk) begin
      if (!I_rst) begin
         state       <= ST_RUN;
         O_stall_cnt <= 16'd0;
      end else begin
         state <= next_state;
         if (O_stall && (O_stall_cnt != 16'hFFFF))
            O_stall_cnt <= O_stall_cnt + 16'd1;
      end
   end

   // MC_WAIT falls through to the RUN decision once busy drops, so a branch
   // resolved on that cycle flushes immediately.
   always_comb begin
      next_state = state;
      O_stall    = 1'b0;
      O_bubble   = 1'b0;
      O_flush    = 1'b0;
      O_fwdA     = FWD_RF;
      O_fwdB     = FWD_RF;
`ifdef CEESPU_FORWARDING_EN
      O_fwdA = fwd_select(ex_hit_a, wb_hit_a);
      O_fwdB = fwd_select(ex_hit_b, wb_hit_b);
`else
      load_use_unused_sink();
`endif
      if (!I_rst) begin
         next_state = ST_RUN;
         O_flush    = 1'b1;
         O_bubble   = 1'b1;
         O_fwdA     = FWD_RF;
         O_fwdB     = FWD_RF;
      end else begin
         case (state)
            ST_FLUSH: begin
               O_flush    = 1'b1;
               O_bubble   = 1'b1;
               next_state = ST_RUN;
            end
            default: begin
               if (I_busy) begin
                  O_stall    = 1'b1;
                  next_state = ST_MC_WAIT;
               end else if (I_branch) begin
                  O_flush    = 1'b1;
                  O_bubble   = 1'b1;
                  next_state = ST_FLUSH;
               end else begin
                  next_state = ST_RUN;
                  if (data_hazard) begin
                     O_stall  = 1'b1;
                     O_bubble = 1'b1;
                  end
               end
            end
         endcase
      end
   end

`ifndef CEESPU_FORWARDING_EN
   // Without forwarding any match stalls, so the load flag carries no extra information.
   function automatic void load_use_unused_sink();
      logic sink;
      sink = load_use;
   endfunction
`endif

endmodule
